// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the data memory pipe: access sizes, FSM states
// and the byte-enable decode.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    function automatic logic [3:0] byte_enables(input size_t size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_memory_pipe_lane_align.sv
// Load-lane selection from a 32-bit word followed by sign or zero extension.
module data_mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (size_t'(size))
            SZ_BYTE: data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            SZ_WORD: data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_pipe.sv
// Byte-addressed MEM-stage data memory with valid/ready requests, a fixed-latency
// in-order response pipeline, error reporting and a post-reset clear sweep.
module data_memory_pipe
    import data_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 2048,
    parameter int READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   clr_cnt;
    logic [31:0]        mem [DEPTH_WORDS];

    logic               accept;
    logic               range_err;
    logic               req_err;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         lane;
    logic [ADDR_W-1:0]  hi_bits;
    logic [3:0]         be;
    logic [31:0]        wdata_lanes;
    logic [31:0]        rd_word;
    logic [31:0]        ld_data;
    logic [31:0]        resp_data_in;

    logic [READ_LAT-1:0] pipe_v;
    logic [READ_LAT-1:0] pipe_e;
    logic [31:0]         pipe_d [READ_LAT];

    // FSM: state register / next state / outputs
    always_ff @(posedge clk) begin
        if (!rst) state <= INIT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && clr_cnt == IDX_W'(DEPTH_WORDS - 1))
            state_nxt = RUN;
    end

    always_comb begin
        req_ready = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst)               clr_cnt <= '0;
        else if (state == INIT) clr_cnt <= clr_cnt + 1'b1;
    end

    // Request decode
    always_comb begin
        accept      = req_valid && req_ready;
        idx         = req_addr[IDX_W+1:2];
        lane        = req_addr[1:0];
        hi_bits     = req_addr >> (IDX_W + 2);
        range_err   = |hi_bits;
        case (size_t'(req_size))
            SZ_BYTE: req_err = range_err;
            SZ_HALF: req_err = range_err | lane[0];
            SZ_WORD: req_err = range_err | (lane != 2'b00);
            default: req_err = 1'b1;
        endcase
        be          = byte_enables(size_t'(req_size), lane);
        wdata_lanes = req_wdata << {lane, 3'b000};
        rd_word     = mem[idx];
        resp_data_in = (req_write || req_err) ? '0 : ld_data;
    end

    data_mem_lane_align u_align (
        .word        (rd_word),
        .lane        (lane),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .data        (ld_data)
    );

    // Storage has no reset; the INIT sweep zeroes it one word per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == INIT) begin
                mem[clr_cnt] <= '0;
            end else if (accept && req_write && !req_err) begin
                for (int unsigned b = 0; b < 4; b++)
                    if (be[b]) mem[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
            end
        end
    end

    // Response pipeline: stage 0 captures at the accepting edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_v <= '0;
            pipe_e <= '0;
            for (int unsigned i = 0; i < READ_LAT; i++) pipe_d[i] <= '0;
        end else begin
            pipe_v[0] <= accept;
            pipe_e[0] <= accept && req_err;
            pipe_d[0] <= accept ? resp_data_in : '0;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_e[i] <= pipe_e[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign resp_valid = pipe_v[READ_LAT-1];
    assign resp_err   = pipe_e[READ_LAT-1];
    assign resp_rdata = pipe_d[READ_LAT-1];

endmodule
